// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter sharing the CPU bus between instruction fetch (m0) and data (m1).
// Round-robin by default; define MIPS_ARB_FIXED_PRIORITY_EN to make m1 win every contest.
module mips_bus_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_waitrequest,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_waitrequest,
   output logic [ADDR_W-1:0]     address,
   output logic                  read,
   output logic                  write,
   output logic [DATA_W-1:0]     writedata,
   output logic [DATA_W/8-1:0]   byteenable,
   input  logic                  waitrequest,
   input  logic [DATA_W-1:0]     readdata
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

   state_e state_q;
   logic   last_q;
   logic   m0_req;
   logic   m1_req;

   assign m0_req = m0_read | m0_write;
   assign m1_req = m1_read | m1_write;

   // Grant is locked until the slave accepts or the owner withdraws its request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_req && m1_req) begin
`ifdef MIPS_ARB_FIXED_PRIORITY_EN
                  state_q <= GRANT1;
`else
                  state_q <= last_q ? GRANT0 : GRANT1;
`endif
               end else if (m0_req) begin
                  state_q <= GRANT0;
               end else if (m1_req) begin
                  state_q <= GRANT1;
               end
            end
            GRANT0: begin
               if (!m0_req) begin
                  state_q <= IDLE;
               end else if (!waitrequest) begin
                  state_q <= IDLE;
                  last_q  <= 1'b0;
               end
            end
            GRANT1: begin
               if (!m1_req) begin
                  state_q <= IDLE;
               end else if (!waitrequest) begin
                  state_q <= IDLE;
                  last_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MIPS_ARB_FIXED_PRIORITY_EN
   logic unused_last;
   assign unused_last = last_q;
`endif

   // Bus mux follows the registered grant, so requests never reach waitrequest combinationally.
   always_comb begin
      address    = '0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      byteenable = '0;
      case (state_q)
         GRANT0: begin
            address    = m0_address;
            read       = m0_read;
            write      = m0_write;
            writedata  = m0_writedata;
            byteenable = m0_byteenable;
         end
         GRANT1: begin
            address    = m1_address;
            read       = m1_read;
            write      = m1_write;
            writedata  = m1_writedata;
            byteenable = m1_byteenable;
         end
         default: ;
      endcase
   end

   assign m0_waitrequest = ~((state_q == GRANT0) & ~waitrequest);
   assign m1_waitrequest = ~((state_q == GRANT1) & ~waitrequest);
   assign m0_readdata    = readdata;
   assign m1_readdata    = readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter; expectations follow MIPS_ARB_FIXED_PRIORITY_EN.
module tb_mips_bus_arbiter;

`ifdef MIPS_ARB_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] address;
   logic        read, write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [31:0] exp_addr;
      reset = 1'b0;
      waitrequest = 1'b1;
      readdata = 32'hDEADBEEF;
      m0_address = 32'h10; m0_read = 1'b1; m0_write = 1'b0;
      m0_writedata = 32'h0; m0_byteenable = 4'hF;
      m1_address = 32'h100; m1_read = 1'b0; m1_write = 1'b1;
      m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;

      // reset held with both masters requesting
      tick(); tick();
      chk("rst_read", 32'(read), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("rst_address", address, 32'h0);
      chk("rst_m0_rdata", m0_readdata, 32'hDEADBEEF);

      @(negedge clk); reset = 1'b1;
      tick();
      chk("rel_address", address, FIXED ? 32'h100 : 32'h10);
      chk("rel_read", 32'(read), FIXED ? 32'd0 : 32'd1);
      chk("rel_write", 32'(write), FIXED ? 32'd1 : 32'd0);

      // both withdraw: back to IDLE, bus quiet
      m0_read = 1'b0; m1_write = 1'b0;
      tick();
      chk("wd_idle_read", 32'(read), 32'd0);
      chk("wd_idle_write", 32'(write), 32'd0);
      chk("wd_idle_wdata", writedata, 32'h0);
      chk("wd_idle_be", 32'(byteenable), 32'd0);

      // m0 zero-wait read
      m0_read = 1'b1; waitrequest = 1'b0;
      tick();
      #1;
      chk("m0rd_read", 32'(read), 32'd1);
      chk("m0rd_address", address, 32'h10);
      chk("m0rd_m0_wait", 32'(m0_waitrequest), 32'd0);
      chk("m0rd_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("m0rd_rdata", m0_readdata, 32'hDEADBEEF);
      tick();
      m0_read = 1'b0;
      #1;
      chk("m0rd_done_read", 32'(read), 32'd0);
      chk("m0rd_done_wait", 32'(m0_waitrequest), 32'd1);

      // m1 write with a 3-cycle slave stall
      m1_write = 1'b1; waitrequest = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("m1wr_write", 32'(write), 32'd1);
         chk("m1wr_address", address, 32'h100);
         chk("m1wr_wdata", writedata, 32'h12345678);
         chk("m1wr_be", 32'(byteenable), 32'd3);
         chk("m1wr_m1_wait_stall", 32'(m1_waitrequest), 32'd1);
         chk("m1wr_m0_wait", 32'(m0_waitrequest), 32'd1);
         tick();
      end
      waitrequest = 1'b0;
      #1;
      chk("m1wr_c4_write", 32'(write), 32'd1);
      chk("m1wr_c4_wdata", writedata, 32'h12345678);
      chk("m1wr_c4_m1_wait", 32'(m1_waitrequest), 32'd0);
      chk("m1wr_c4_m0_wait", 32'(m0_waitrequest), 32'd1);
      tick();
      m1_write = 1'b0;
      #1;
      chk("m1wr_done_write", 32'(write), 32'd0);
      chk("m1wr_done_wait", 32'(m1_waitrequest), 32'd1);

      // continuous contest, zero-wait slave
      m0_address = 32'h20; m0_read = 1'b1;
      m1_address = 32'h200; m1_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i % 2 == 1) exp_addr = 32'h0;
         else if (FIXED) exp_addr = 32'h200;
         else exp_addr = (i % 4 == 0) ? 32'h20 : 32'h200;
         chk("rr_address", address, exp_addr);
         chk("rr_read", 32'(read), (exp_addr != 32'h0) ? 32'd1 : 32'd0);
         chk("rr_m0_wait", 32'(m0_waitrequest), (exp_addr == 32'h20) ? 32'd0 : 32'd1);
      end
      m0_read = 1'b0; m1_read = 1'b0;

      // reset mid-stall during GRANT1 write
      m1_address = 32'h300; m1_write = 1'b1; waitrequest = 1'b1;
      tick();
      chk("mid_write", 32'(write), 32'd1);
      chk("mid_address", address, 32'h300);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_write", 32'(write), 32'd0);
      chk("mid_rst_address", address, 32'h0);
      chk("mid_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      m0_address = 32'h40; m0_read = 1'b1;
      @(negedge clk); reset = 1'b1;
      tick();
      chk("post_rst_address", address, FIXED ? 32'h300 : 32'h40);
      m0_read = 1'b0; m1_write = 1'b0;
      tick();
      chk("post_rst_idle", 32'(read | write), 32'd0);

      // granted m0 withdraws mid-stall, pending m1 follows
      m0_read = 1'b1;
      tick();
      chk("wd_g0_read", 32'(read), 32'd1);
      chk("wd_g0_m0_wait", 32'(m0_waitrequest), 32'd1);
      m0_read = 1'b0; m1_write = 1'b1;
      #1;
      chk("wd_fwd_read", 32'(read), 32'd0);
      chk("wd_fwd_write", 32'(write), 32'd0);
      tick();
      chk("wd_idle2_write", 32'(write), 32'd0);
      chk("wd_idle2_m1_wait", 32'(m1_waitrequest), 32'd1);
      tick();
      chk("wd_g1_write", 32'(write), 32'd1);
      chk("wd_g1_address", address, 32'h300);
      chk("wd_g1_m1_wait", 32'(m1_waitrequest), 32'd1);
      waitrequest = 1'b0; readdata = 32'hCAFEF00D;
      #1;
      chk("wd_g1_m1_wait_go", 32'(m1_waitrequest), 32'd0);
      chk("m1_rdata_pass", m1_readdata, 32'hCAFEF00D);
      tick();
      m1_write = 1'b0;
      #1;
      chk("end_idle_write", 32'(write), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
